store_write_buffer: RTL and testbench

- Load/store front end directly upstream of the byte-addressable data memory.
- Accepts stores from the pipeline MEM stage into a small FIFO and drains them to the memory port in idle cycles.
- Loads have priority on the memory port; an exact-address store-to-load forward is served from the buffer.
- Partial byte overlap between a load and a buffered store stalls the load until the buffer has drained far enough to remove the overlap.

---
 rtl/store_write_buffer.sv | 132 +++++++++++++
 tb/tb_store_write_buffer.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/store_write_buffer.sv
// ============================================================================
// Module   : store_write_buffer
// Purpose  : Store FIFO in front of a byte-addressable data memory. Stores
//            drain in idle port cycles, loads take priority, exact-address
//            loads are forwarded from the buffer and partially overlapping
//            loads stall until the overlapping store has drained.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module store_write_buffer #(
   parameter int DEPTH = 4,
   parameter int AW    = 16,
   parameter int DW    = 16
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          st_valid,
   output logic          st_ready,
   input  logic [AW-1:0] st_addr,
   input  logic [DW-1:0] st_data,
   input  logic          ld_valid,
   output logic          ld_ready,
   input  logic [AW-1:0] ld_addr,
   output logic          ld_rvalid,
   output logic [DW-1:0] ld_rdata,
   output logic          empty,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   output logic          mem_read,
   output logic          mem_write,
   input  logic [DW-1:0] mem_rdata
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [AW-1:0] buf_addr [DEPTH];
   logic [DW-1:0] buf_data [DEPTH];
   logic [PW-1:0] head;
   logic [PW-1:0] tail;
   logic [CW-1:0] count;

   logic          hit;
   logic          partial;
   logic [DW-1:0] fwd_data;
   logic [PW-1:0] idx;
   logic          accept;
   logic          push;
   logic          pop;

   // Scan live entries oldest to youngest so the last exact match found is the youngest.
   always_comb begin
      hit      = 1'b0;
      partial  = 1'b0;
      fwd_data = '0;
      idx      = '0;
      for (int k = 0; k < DEPTH; k++) begin
         idx = head + PW'(k);
         if (CW'(k) < count) begin
            if (buf_addr[idx] == ld_addr) begin
               hit      = 1'b1;
               fwd_data = buf_data[idx];
            end
            // Neighbouring word start addresses share one byte (AW-bit wrap).
            if ((buf_addr[idx] == ld_addr + AW'(1)) ||
                (buf_addr[idx] + AW'(1) == ld_addr)) begin
               partial = 1'b1;
            end
         end
      end
   end

   // Port arbitration: an accepted unforwarded load owns the port, otherwise drain the head.
   always_comb begin
      st_ready  = (count != CW'(DEPTH));
      empty     = (count == '0);
      ld_ready  = !partial;
      accept    = ld_valid && ld_ready;
      push      = st_valid && st_ready;
      mem_read  = accept && !hit;
      pop       = (count != '0) && !mem_read;
      mem_write = pop;
      mem_addr  = '0;
      mem_wdata = '0;
      if (mem_read) begin
         mem_addr = ld_addr;
      end else if (pop) begin
         mem_addr  = buf_addr[head];
         mem_wdata = buf_data[head];
      end
   end

   // Entry storage needs no reset; validity is tracked by head/count.
   always_ff @(posedge clk) begin
      if (push) begin
         buf_addr[tail] <= st_addr;
         buf_data[tail] <= st_data;
      end
   end

   // FIFO pointers and occupancy.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (push) tail <= tail + PW'(1);
         if (pop)  head <= head + PW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Load response register: forwarded data or memory data, one cycle after accept.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ld_rvalid <= 1'b0;
         ld_rdata  <= '0;
      end else begin
         ld_rvalid <= accept;
         if (accept) ld_rdata <= hit ? fwd_data : mem_rdata;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_store_write_buffer.sv
// ============================================================================
// Module   : tb_store_write_buffer
// Purpose  : Directed vector bench for store_write_buffer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_store_write_buffer;

   logic        clk = 1'b0;
   logic        reset;
   logic        st_valid, ld_valid;
   logic [15:0] st_addr, st_data, ld_addr;
   logic        st_ready, ld_ready, ld_rvalid, empty, mem_read, mem_write;
   logic [15:0] ld_rdata, mem_addr, mem_wdata, mem_rdata;

   int tests = 0;
   int fails = 0;

   // Memory read data is a fixed function of the address.
   assign mem_rdata = mem_addr ^ 16'hC3A5;

   always #5 clk = ~clk;

   store_write_buffer #(.DEPTH(4), .AW(16), .DW(16)) dut (
      .clk(clk), .reset(reset),
      .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr), .st_data(st_data),
      .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr),
      .ld_rvalid(ld_rvalid), .ld_rdata(ld_rdata), .empty(empty),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read),
      .mem_write(mem_write), .mem_rdata(mem_rdata)
   );

   typedef struct {
      logic        sv;
      logic [15:0] sa, sd;
      logic        lv;
      logic [15:0] la;
      logic        e_sr, e_lr, e_mr, e_mw;
      logic [15:0] e_ma, e_wd;
      logic        e_em, e_rv;
      logic [15:0] e_rd;
   } vec_t;

   vec_t vt [30];

   function automatic vec_t mk(logic sv, logic [15:0] sa, logic [15:0] sd, logic lv,
                               logic [15:0] la, logic sr, logic lr, logic mr, logic mw,
                               logic [15:0] ma, logic [15:0] wd, logic em, logic rv,
                               logic [15:0] rd);
      vec_t v;
      v.sv = sv; v.sa = sa; v.sd = sd; v.lv = lv; v.la = la;
      v.e_sr = sr; v.e_lr = lr; v.e_mr = mr; v.e_mw = mw;
      v.e_ma = ma; v.e_wd = wd; v.e_em = em; v.e_rv = rv; v.e_rd = rd;
      return v;
   endfunction

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic sv, input logic [15:0] sa, input logic [15:0] sd,
                        input logic lv, input logic [15:0] la);
      st_valid = sv; st_addr = sa; st_data = sd; ld_valid = lv; ld_addr = la;
   endtask

   initial begin
      // Stores 0x0010/0x0020 drain on consecutive idle cycles.
      vt[0]  = mk(0,16'h0000,16'h0000,0,16'h0000, 1,1,0,0,16'h0000,16'h0000,1,0,16'h0000);
      vt[1]  = mk(1,16'h0010,16'hBEEF,0,16'h0000, 1,1,0,0,16'h0000,16'h0000,1,0,16'h0000);
      vt[2]  = mk(1,16'h0020,16'h1234,0,16'h0000, 1,1,0,1,16'h0010,16'hBEEF,0,0,16'h0000);
      vt[3]  = mk(0,16'h0000,16'h0000,0,16'h0000, 1,1,0,1,16'h0020,16'h1234,0,0,16'h0000);
      vt[4]  = mk(0,16'h0000,16'h0000,0,16'h0000, 1,1,0,0,16'h0000,16'h0000,1,0,16'h0000);
      // Fill to full while loads keep the port busy; fifth store held.
      vt[5]  = mk(1,16'h0100,16'h0001,1,16'h0030, 1,1,1,0,16'h0030,16'h0000,1,0,16'h0000);
      vt[6]  = mk(1,16'h0102,16'h0002,1,16'h0030, 1,1,1,0,16'h0030,16'h0000,0,1,16'hC395);
      vt[7]  = mk(1,16'h0104,16'h0003,1,16'h0030, 1,1,1,0,16'h0030,16'h0000,0,1,16'hC395);
      vt[8]  = mk(1,16'h0106,16'h0004,1,16'h0030, 1,1,1,0,16'h0030,16'h0000,0,1,16'hC395);
      vt[9]  = mk(1,16'h0108,16'h0005,1,16'h0030, 0,1,1,0,16'h0030,16'h0000,0,1,16'hC395);
      vt[10] = mk(1,16'h0108,16'h0005,0,16'h0000, 0,1,0,1,16'h0100,16'h0001,0,1,16'hC395);
      vt[11] = mk(1,16'h0108,16'h0005,0,16'h0000, 1,1,0,1,16'h0102,16'h0002,0,0,16'hC395);
      vt[12] = mk(0,16'h0000,16'h0000,0,16'h0000, 1,1,0,1,16'h0104,16'h0003,0,0,16'hC395);
      vt[13] = mk(0,16'h0000,16'h0000,0,16'h0000, 1,1,0,1,16'h0106,16'h0004,0,0,16'hC395);
      vt[14] = mk(0,16'h0000,16'h0000,0,16'h0000, 1,1,0,1,16'h0108,16'h0005,0,0,16'hC395);
      vt[15] = mk(0,16'h0000,16'h0000,0,16'h0000, 1,1,0,0,16'h0000,16'h0000,1,0,16'hC395);
      // Two stores to 0x0040; load forwards the youngest while the older drains.
      vt[16] = mk(1,16'h0040,16'hAAAA,1,16'h0030, 1,1,1,0,16'h0030,16'h0000,1,0,16'hC395);
      vt[17] = mk(1,16'h0040,16'h5555,1,16'h0030, 1,1,1,0,16'h0030,16'h0000,0,1,16'hC395);
      vt[18] = mk(0,16'h0000,16'h0000,1,16'h0040, 1,1,0,1,16'h0040,16'hAAAA,0,1,16'hC395);
      vt[19] = mk(0,16'h0000,16'h0000,0,16'h0000, 1,1,0,1,16'h0040,16'h5555,0,1,16'h5555);
      vt[20] = mk(0,16'h0000,16'h0000,0,16'h0000, 1,1,0,0,16'h0000,16'h0000,1,0,16'h5555);
      // Partial overlap: entry 0x0041, load 0x0040.
      vt[21] = mk(1,16'h0041,16'h1111,1,16'h0030, 1,1,1,0,16'h0030,16'h0000,1,0,16'h5555);
      vt[22] = mk(0,16'h0000,16'h0000,1,16'h0040, 1,0,0,1,16'h0041,16'h1111,0,1,16'hC395);
      vt[23] = mk(0,16'h0000,16'h0000,1,16'h0040, 1,1,1,0,16'h0040,16'h0000,1,0,16'hC395);
      // Wrap: entry 0x0000, load 0xFFFF.
      vt[24] = mk(1,16'h0000,16'h2222,1,16'h0030, 1,1,1,0,16'h0030,16'h0000,1,1,16'hC3E5);
      vt[25] = mk(0,16'h0000,16'h0000,1,16'hFFFF, 1,0,0,1,16'h0000,16'h2222,0,1,16'hC395);
      vt[26] = mk(0,16'h0000,16'h0000,1,16'hFFFF, 1,1,1,0,16'hFFFF,16'h0000,1,0,16'hC395);
      // Other overlap direction: entry 0x0050, load 0x0051.
      vt[27] = mk(1,16'h0050,16'h3333,1,16'h0030, 1,1,1,0,16'h0030,16'h0000,1,1,16'h3C5A);
      vt[28] = mk(0,16'h0000,16'h0000,1,16'h0051, 1,0,0,1,16'h0050,16'h3333,0,1,16'hC395);
      vt[29] = mk(0,16'h0000,16'h0000,0,16'h0000, 1,1,0,0,16'h0000,16'h0000,1,0,16'hC395);

      // Reset state
      reset = 1'b0;
      drive(0, 16'h0, 16'h0, 0, 16'h0);
      #2;
      chk("rst st_ready",  {15'b0, st_ready},  16'd1);
      chk("rst ld_ready",  {15'b0, ld_ready},  16'd1);
      chk("rst empty",     {15'b0, empty},     16'd1);
      chk("rst mem_read",  {15'b0, mem_read},  16'd0);
      chk("rst mem_write", {15'b0, mem_write}, 16'd0);
      chk("rst mem_addr",  mem_addr,  16'h0000);
      chk("rst mem_wdata", mem_wdata, 16'h0000);
      chk("rst ld_rvalid", {15'b0, ld_rvalid}, 16'd0);
      chk("rst ld_rdata",  ld_rdata,  16'h0000);
      @(posedge clk); #1 reset = 1'b1;

      // Table vectors: drive after the edge, compare mid-cycle.
      for (int i = 0; i < 30; i++) begin
         @(posedge clk); #1;
         drive(vt[i].sv, vt[i].sa, vt[i].sd, vt[i].lv, vt[i].la);
         #2;
         chk($sformatf("row%0d st_ready", i),  {15'b0, st_ready},  {15'b0, vt[i].e_sr});
         chk($sformatf("row%0d ld_ready", i),  {15'b0, ld_ready},  {15'b0, vt[i].e_lr});
         chk($sformatf("row%0d mem_read", i),  {15'b0, mem_read},  {15'b0, vt[i].e_mr});
         chk($sformatf("row%0d mem_write", i), {15'b0, mem_write}, {15'b0, vt[i].e_mw});
         chk($sformatf("row%0d mem_addr", i),  mem_addr,  vt[i].e_ma);
         chk($sformatf("row%0d mem_wdata", i), mem_wdata, vt[i].e_wd);
         chk($sformatf("row%0d empty", i),     {15'b0, empty},     {15'b0, vt[i].e_em});
         chk($sformatf("row%0d ld_rvalid", i), {15'b0, ld_rvalid}, {15'b0, vt[i].e_rv});
         chk($sformatf("row%0d ld_rdata", i),  ld_rdata,  vt[i].e_rd);
      end

      // Reset while three stores are buffered and one is draining.
      @(posedge clk); #1 drive(1, 16'h0200, 16'h0A0A, 1, 16'h0030);
      @(posedge clk); #1 drive(1, 16'h0202, 16'h0B0B, 1, 16'h0030);
      @(posedge clk); #1 drive(1, 16'h0204, 16'h0C0C, 1, 16'h0030);
      @(posedge clk); #1 drive(0, 16'h0, 16'h0, 0, 16'h0);
      #1;
      chk("pre-rst mem_write", {15'b0, mem_write}, 16'd1);
      chk("pre-rst mem_addr",  mem_addr, 16'h0200);
      chk("pre-rst ld_rvalid", {15'b0, ld_rvalid}, 16'd1);
      reset = 1'b0;
      #1;
      chk("mid-rst mem_write", {15'b0, mem_write}, 16'd0);
      chk("mid-rst empty",     {15'b0, empty},     16'd1);
      chk("mid-rst st_ready",  {15'b0, st_ready},  16'd1);
      chk("mid-rst ld_rvalid", {15'b0, ld_rvalid}, 16'd0);
      @(posedge clk);
      @(posedge clk); #1 reset = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(posedge clk); #2;
         chk($sformatf("post-rst%0d mem_write", c), {15'b0, mem_write}, 16'd0);
         chk($sformatf("post-rst%0d empty", c),     {15'b0, empty},     16'd1);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

`default_nettype wire
